// File: rtl/pipe_skid_buffer_x65.sv
// Two-entry valid/ready skid buffer feeding a 65-bit {valid, data} pipeline register wall.
// Optional stall-cycle counter is enabled by defining PIPE_SKID_STALL_CNT_EN.
module pipe_skid_buffer_x65 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             softReset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_packed,
`ifdef PIPE_SKID_STALL_CNT_EN
  output logic [31:0]      stall_cycles,
`endif
  output logic [1:0]       occupancy
);

  // state | meaning
  // EMPTY | no entries; main reads 0
  // BUSY  | main holds the head word
  // FULL  | main holds the head, skid holds the next word
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  // Handshake outputs decode from state only, so in_ready never sees out_ready.
  assign out_valid  = (state_q != EMPTY);
  assign in_ready   = (state_q != FULL);
  assign occupancy  = state_q;
  assign out_data   = main_q;
  assign out_packed = {out_valid, main_q};

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = FULL;
        end else if (out_fire) begin
          // Clearing main on drain keeps out_packed at zero while idle.
          main_d  = '0;
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: begin
        main_d  = '0;
        skid_d  = '0;
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || softReset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Survives softReset so flushes do not hide accumulated stall history.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule
